// File: rtl/adc_sample_buffer.sv
// adc_sample_buffer
//   Captures up to DEPTH samples from the SPI ADC controller into a synchronous
//   RAM. Each sample is qualified by ready_in. The samples are then drained to
//   the host link as two bytes per sample (high byte first) over a valid/ack
//   handshake. This lets the ADC sample rate and the link rate differ.
//
//   Optional build macro: ADC_BUF_CHECKSUM_EN
//     When defined, a trailing XOR checksum byte of all transmitted data bytes
//     is sent after the last sample, and done follows that byte's ack.
//     When undefined, done follows the ack of the last sample's low byte.
//
// Ports
//   clk_in    system clock
//   rst_n     asynchronous active-low reset
//   arm       start pulse; n is latched on it (ignored unless idle)
//   n         number of samples to capture (clamped to DEPTH)
//   data_in   sample word, qualified by ready_in
//   ready_in  sample strobe (ignored unless capturing)
//   tx_data   byte presented to the link
//   tx_valid  tx_data valid; held until tx_ack
//   tx_ack    byte accepted
//   busy      high whenever not idle
//   done      one-cycle pulse at the end of a run
//   overflow  sticky flag, set when n exceeded DEPTH; cleared on the next arm
//   count     number of samples captured in the current or last run
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for arm
// S_CAPTURE  | writing qualified samples to RAM until count == n_lat
// S_FETCH    | RAM read address = rp; read data is ready next cycle
// S_SEND_HI  | presenting the upper sample bits as a byte
// S_SEND_LO  | presenting sample[7:0]; on its ack, next sample or finish
// S_CHK      | presenting the XOR checksum byte (checksum build only)
module adc_sample_buffer #(
  parameter int DATA_W     = 12,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [11:0]       n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready_in,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ack,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [11:0]       count
);

  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [12:0] DEPTH_W = 13'(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_SEND_HI = 3'd3;
  localparam logic [2:0] S_SEND_LO = 3'd4;
  localparam logic [2:0] S_CHK     = 3'd5;

  logic [2:0]            state;
  logic [11:0]           n_lat;
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     rd_data;
  logic [15:0]           rd_ext;
  logic                  wr_en;
  logic                  last_wr;
  logic                  last_rd;
  logic                  n_over;
`ifdef ADC_BUF_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  // Zero-extending to 16 bits gives the high byte {(16-DATA_W)'b0, sample[DATA_W-1:8]}.
  assign rd_ext  = 16'(rd_data);
  assign wr_en   = (state == S_CAPTURE) && ready_in;
  assign last_wr = ((count + 12'd1) == n_lat);
  assign last_rd = (12'(rp) == (n_lat - 12'd1));
  assign n_over  = ({1'b0, n} > DEPTH_W);
  assign busy    = (state != S_IDLE);

  // Sample storage is not reset. The read port is registered every cycle, and
  // rp only moves on the final ack of a sample.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wp] <= data_in;
    rd_data <= mem[rp];
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      n_lat    <= '0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
`ifdef ADC_BUF_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arm) begin
            n_lat    <= n_over ? DEPTH_W[11:0] : n;
            overflow <= n_over;
            count    <= '0;
            wp       <= '0;
            rp       <= '0;
`ifdef ADC_BUF_CHECKSUM_EN
            csum     <= '0;
`endif
            if (n == 12'd0) done  <= 1'b1;
            else            state <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          if (ready_in) begin
            wp    <= wp + 1'b1;
            count <= count + 12'd1;
            if (last_wr) state <= S_FETCH;
          end
        end

        S_FETCH: state <= S_SEND_HI;

        // Each send state raises tx_valid one cycle after it is entered. This
        // guarantees an idle cycle after every ack before the next byte.
        S_SEND_HI: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= rd_ext[15:8];
          end else if (tx_ack) begin
            tx_valid <= 1'b0;
`ifdef ADC_BUF_CHECKSUM_EN
            csum     <= csum ^ tx_data;
`endif
            state    <= S_SEND_LO;
          end
        end

        S_SEND_LO: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= rd_ext[7:0];
          end else if (tx_ack) begin
            tx_valid <= 1'b0;
            rp       <= rp + 1'b1;
`ifdef ADC_BUF_CHECKSUM_EN
            csum     <= csum ^ tx_data;
            if (last_rd) state <= S_CHK;
            else         state <= S_FETCH;
`else
            if (last_rd) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_FETCH;
            end
`endif
          end
        end

`ifdef ADC_BUF_CHECKSUM_EN
        S_CHK: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= csum;
          end else if (tx_ack) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= S_IDLE;
          end
        end
`endif

        default: begin
          tx_valid <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
